// File: rtl/frame_wr_ctrl_if.sv
// Pixel-in / buffer-write signal bundle for frame_wr_ctrl.
// master = pixel source plus frame buffer side, slave = the write controller.
interface frame_wr_ctrl_if #(
   parameter int PIX_WIDTH  = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  sof;
   logic                  pix_valid;
   logic [PIX_WIDTH-1:0]  pix_data;
   logic                  wr_rdy;
   logic                  wr_en_l;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  frame_done;
   logic                  overflow;
   logic                  busy;

   modport master (
      output sof, pix_valid, pix_data, wr_rdy,
      input  wr_en_l, data_out, frame_done, overflow, busy
   );

   modport slave (
      input  sof, pix_valid, pix_data, wr_rdy,
      output wr_en_l, data_out, frame_done, overflow, busy
   );
endinterface

// File: rtl/frame_wr_ctrl.sv
// Packs pixels into buffer words and writes exactly BUF_SIZE words per frame; a word is offered the cycle after its last pixel.
// wr_rdy stalls are absorbed by a FIFO_DEPTH skid FIFO; a word completing into a full, non-popping FIFO is dropped (sticky overflow).
module frame_wr_ctrl #(
   parameter int PIX_WIDTH  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int BUF_SIZE   = 500,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           wr_clk,
   input  logic           reset,
   frame_wr_ctrl_if.slave bus_if
);
   localparam int PPW = DATA_WIDTH / PIX_WIDTH;
   localparam int PIW = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int WCW = $clog2(BUF_SIZE + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DRAIN
   } state_t;

   state_t                state_q, state_d;
   logic [PIW-1:0]        pidx_q, pidx_d;
   logic [DATA_WIDTH-1:0] pack_q, pack_d;
   logic [WCW-1:0]        wcnt_q, wcnt_d;
   logic                  frame_done_q, frame_done_d;
   logic                  overflow_q;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]         fcnt_q, fcnt_d;

   logic                  take_pix;
   logic                  word_done;
   logic [PIW-1:0]        slot;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  pop;
   logic                  push;
   logic                  drop;
   logic                  drain_empty;

   assign fifo_empty  = (fcnt_q == '0);
   assign fifo_full   = (fcnt_q == CW'(FIFO_DEPTH));
   assign pop         = !fifo_empty && bus_if.wr_rdy;
   assign push        = word_done && (!fifo_full || pop);
   assign drop        = word_done && fifo_full && !pop;
   // Only pops happen in DRAIN, so the FIFO empties at this edge iff the last entry leaves now.
   assign drain_empty = fifo_empty || (pop && (fcnt_q == CW'(1)));

   always_comb begin
      state_d      = state_q;
      pidx_d       = pidx_q;
      pack_d       = pack_q;
      wcnt_d       = wcnt_q;
      frame_done_d = 1'b0;
      take_pix     = 1'b0;
      slot         = pidx_q;

      case (state_q)
         ST_IDLE: begin
            if (bus_if.pix_valid && bus_if.sof) begin
               take_pix = 1'b1;
               slot     = '0;
               wcnt_d   = '0;
               state_d  = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (bus_if.pix_valid) begin
               take_pix = 1'b1;
               // A mid-frame sof abandons the partial word and restarts the frame.
               if (bus_if.sof) begin
                  slot   = '0;
                  wcnt_d = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_empty) begin
               frame_done_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      word_done = take_pix && (slot == PIW'(PPW - 1));

      if (take_pix) begin
         pack_d[int'(slot) * PIX_WIDTH +: PIX_WIDTH] = bus_if.pix_data;
         pidx_d = word_done ? '0 : slot + 1'b1;
      end

      if (word_done) begin
         wcnt_d = wcnt_d + 1'b1;
         if (wcnt_d == WCW'(BUF_SIZE)) begin
            state_d = ST_DRAIN;
         end
      end
   end

   always_comb begin
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + 1'b1;
         2'b01:   fcnt_d = fcnt_q - 1'b1;
         default: fcnt_d = fcnt_q;
      endcase
   end

   always_ff @(posedge wr_clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pidx_q       <= '0;
         pack_q       <= '0;
         wcnt_q       <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pidx_q       <= pidx_d;
         pack_q       <= pack_d;
         wcnt_q       <= wcnt_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_q | drop;
      end
   end

   always_ff @(posedge wr_clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fcnt_q   <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= pack_d;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         fcnt_q <= fcnt_d;
      end
   end

   assign bus_if.wr_en_l    = fifo_empty;
   assign bus_if.data_out   = fifo_empty ? '0 : mem_q[rd_ptr_q];
   assign bus_if.frame_done = frame_done_q;
   assign bus_if.overflow   = overflow_q;
   assign bus_if.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_frame_wr_ctrl.sv
// Drives two frame_wr_ctrl instances (BUF_SIZE 4 and 6) with identical stimulus and checks
// both against a queue-based frame/word model plus directed expectations.
module tb_frame_wr_ctrl;
   localparam int DEPTH = 4;
   localparam int QMAX  = 8;
   localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2;
   localparam logic [35:0] RST_VEC = {1'b1, 35'd0};

   logic       wr_clk = 1'b0;
   logic       reset = 1'b0;
   logic       sof = 1'b0;
   logic       pv = 1'b0;
   logic [7:0] pix = 8'h00;
   logic       rdy = 1'b0;

   always #5 wr_clk = ~wr_clk;

   frame_wr_ctrl_if #(.PIX_WIDTH(8), .DATA_WIDTH(32)) if_a ();
   frame_wr_ctrl_if #(.PIX_WIDTH(8), .DATA_WIDTH(32)) if_b ();

   assign if_a.sof = sof;
   assign if_a.pix_valid = pv;
   assign if_a.pix_data = pix;
   assign if_a.wr_rdy = rdy;
   assign if_b.sof = sof;
   assign if_b.pix_valid = pv;
   assign if_b.pix_data = pix;
   assign if_b.wr_rdy = rdy;

   frame_wr_ctrl #(.PIX_WIDTH(8), .DATA_WIDTH(32), .BUF_SIZE(4), .FIFO_DEPTH(DEPTH)) dut_a (
      .wr_clk(wr_clk), .reset(reset), .bus_if(if_a));
   frame_wr_ctrl #(.PIX_WIDTH(8), .DATA_WIDTH(32), .BUF_SIZE(6), .FIFO_DEPTH(DEPTH)) dut_b (
      .wr_clk(wr_clk), .reset(reset), .bus_if(if_b));

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   // Reference model state, one slot per instance.
   int          m_state [2];
   logic [31:0] m_word [2];
   int          m_npix [2];
   int          m_wcnt [2];
   logic [31:0] m_q [2][QMAX];
   int          m_n [2];
   bit          m_fd [2];
   bit          m_ovf [2];
   int          m_frames [2];

   logic [31:0] popped_a [$];
   logic [31:0] popped_b [$];
   int fd_a, fd_b, fd_cyc_a, last_pop_a;

   task automatic model_step(input int d);
      int  bsz;
      bit  do_pop;
      bsz = (d == 0) ? 4 : 6;
      m_fd[d] = 1'b0;
      if (reset) begin
         m_state[d] = M_IDLE; m_word[d] = 32'h0; m_npix[d] = 0; m_wcnt[d] = 0;
         m_n[d] = 0; m_ovf[d] = 1'b0;
         return;
      end
      do_pop = (m_n[d] > 0) && rdy;
      if (do_pop) begin
         for (int k = 0; k < QMAX - 1; k++) m_q[d][k] = m_q[d][k+1];
         m_n[d]--;
      end
      if (pv && sof && (m_state[d] == M_IDLE || m_state[d] == M_CAP)) begin
         m_state[d] = M_CAP; m_word[d] = 32'h0; m_npix[d] = 0; m_wcnt[d] = 0;
      end
      if (m_state[d] == M_CAP && pv) begin
         m_word[d] = m_word[d] | (32'(pix) << (8 * m_npix[d]));
         m_npix[d]++;
         if (m_npix[d] == 4) begin
            m_wcnt[d]++;
            if (m_n[d] < DEPTH) begin
               m_q[d][m_n[d]] = m_word[d];
               m_n[d]++;
            end else begin
               m_ovf[d] = 1'b1;
            end
            m_word[d] = 32'h0;
            m_npix[d] = 0;
            if (m_wcnt[d] == bsz) m_state[d] = M_DRAIN;
         end
      end else if (m_state[d] == M_DRAIN && m_n[d] == 0) begin
         m_fd[d] = 1'b1;
         m_state[d] = M_IDLE;
         m_frames[d]++;
      end
   endtask

   function automatic logic [35:0] exp_vec(input int d);
      logic [31:0] w;
      w = (m_n[d] > 0) ? m_q[d][0] : 32'h0;
      return {(m_n[d] == 0), w, m_fd[d], m_ovf[d], (m_state[d] != M_IDLE)};
   endfunction

   function automatic logic [35:0] act_vec(input int d);
      if (d == 0) return {if_a.wr_en_l, if_a.data_out, if_a.frame_done, if_a.overflow, if_a.busy};
      return {if_b.wr_en_l, if_b.data_out, if_b.frame_done, if_b.overflow, if_b.busy};
   endfunction

   task automatic tick();
      for (int d = 0; d < 2; d++) model_step(d);
      if (!reset && !if_a.wr_en_l && rdy) begin
         popped_a.push_back(if_a.data_out);
         last_pop_a = cyc;
      end
      if (!reset && !if_b.wr_en_l && rdy) popped_b.push_back(if_b.data_out);
      @(posedge wr_clk);
      cyc++;
      #1;
      if (if_a.frame_done === 1'b1) begin fd_a++; fd_cyc_a = cyc; end
      if (if_b.frame_done === 1'b1) fd_b++;
   endtask

   task automatic do_reset();
      reset = 1'b1; sof = 1'b0; pv = 1'b0; pix = 8'h00; rdy = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      popped_a.delete(); popped_b.delete();
      fd_a = 0; fd_b = 0; fd_cyc_a = -1; last_pop_a = -100;
      m_frames[0] = 0; m_frames[1] = 0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (act_vec(d) !== RST_VEC) $display("FAIL reset_values dut%0d: got %h, expected %h", d, act_vec(d), RST_VEC);
         else n_pass++;
      end
   endtask

   task automatic test_basic();
      logic [31:0] exp_w [4];
      logic [31:0] w;
      exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      do_reset();
      rdy = 1'b1;
      for (int i = 0; i < 26; i++) begin
         pv = (i < 16); sof = (i == 0); pix = 8'(i);
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vec(d) !== exp_vec(d)) $display("FAIL basic_model dut%0d cyc %0d: got %h, expected %h", d, cyc, act_vec(d), exp_vec(d));
            else n_pass++;
         end
         if (i == 2 || i == 3) begin
            n_checks++;
            if (if_a.wr_en_l !== (i == 2)) $display("FAIL basic_latency after pixel %0d: wr_en_l %b, expected %b", i, if_a.wr_en_l, (i == 2));
            else n_pass++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         w = (k < popped_a.size()) ? popped_a[k] : 32'hxxxxxxxx;
         n_checks++;
         if (w !== exp_w[k]) $display("FAIL basic_word%0d: got %h, expected %h", k, w, exp_w[k]);
         else n_pass++;
      end
      n_checks++;
      if (popped_a.size() != 4 || fd_a != 1 || if_a.overflow !== 1'b0)
         $display("FAIL basic_summary: writes %0d frame_done %0d overflow %b, expected 4 1 0", popped_a.size(), fd_a, if_a.overflow);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_w [4];
      logic [31:0] w;
      exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      do_reset();
      for (int i = 0; i < 30; i++) begin
         pv = (i < 16); sof = (i == 0); pix = 8'(i); rdy = !(i >= 4 && i < 14);
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vec(d) !== exp_vec(d)) $display("FAIL bp_model dut%0d cyc %0d: got %h, expected %h", d, cyc, act_vec(d), exp_vec(d));
            else n_pass++;
         end
         if (i >= 3 && i < 14) begin
            n_checks++;
            if ({if_a.wr_en_l, if_a.data_out} !== {1'b0, 32'h03020100})
               $display("FAIL bp_hold cyc %0d: wr_en_l/data %b/%h, expected 0/03020100", cyc, if_a.wr_en_l, if_a.data_out);
            else n_pass++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         w = (k < popped_a.size()) ? popped_a[k] : 32'hxxxxxxxx;
         n_checks++;
         if (w !== exp_w[k]) $display("FAIL bp_word%0d: got %h, expected %h", k, w, exp_w[k]);
         else n_pass++;
      end
      n_checks++;
      if (fd_a != 1 || fd_cyc_a != last_pop_a + 1 || popped_a.size() != 4)
         $display("FAIL bp_done: frame_done %0d at cyc %0d, last pop %0d, writes %0d", fd_a, fd_cyc_a, last_pop_a, popped_a.size());
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [31:0] exp_w [4];
      logic [31:0] w;
      exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      do_reset();
      for (int i = 0; i < 40; i++) begin
         pv = (i < 24); sof = (i == 0); pix = 8'(i); rdy = (i >= 24);
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vec(d) !== exp_vec(d)) $display("FAIL ovf_model dut%0d cyc %0d: got %h, expected %h", d, cyc, act_vec(d), exp_vec(d));
            else n_pass++;
         end
         if (i == 18 || i == 19) begin
            n_checks++;
            if (if_b.overflow !== (i == 19)) $display("FAIL ovf_onset after pixel %0d: got %b, expected %b", i, if_b.overflow, (i == 19));
            else n_pass++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         w = (k < popped_b.size()) ? popped_b[k] : 32'hxxxxxxxx;
         n_checks++;
         if (w !== exp_w[k]) $display("FAIL ovf_word%0d: got %h, expected %h", k, w, exp_w[k]);
         else n_pass++;
      end
      n_checks++;
      if (popped_b.size() != 4 || fd_b != 1 || if_b.overflow !== 1'b1)
         $display("FAIL ovf_summary: writes %0d frame_done %0d overflow %b, expected 4 1 1", popped_b.size(), fd_b, if_b.overflow);
      else n_pass++;
   endtask

   task automatic test_midframe_sof();
      logic [31:0] exp_w [5];
      logic [31:0] w;
      exp_w = '{32'h03020100, 32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
      do_reset();
      rdy = 1'b1;
      for (int i = 0; i < 32; i++) begin
         pv = (i < 22); sof = (i == 0 || i == 6);
         pix = (i < 6) ? 8'(i) : 8'(16 + i - 6);
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vec(d) !== exp_vec(d)) $display("FAIL mid_model dut%0d cyc %0d: got %h, expected %h", d, cyc, act_vec(d), exp_vec(d));
            else n_pass++;
         end
      end
      for (int k = 0; k < 5; k++) begin
         w = (k < popped_a.size()) ? popped_a[k] : 32'hxxxxxxxx;
         n_checks++;
         if (w !== exp_w[k]) $display("FAIL mid_word%0d: got %h, expected %h", k, w, exp_w[k]);
         else n_pass++;
      end
      n_checks++;
      if (popped_a.size() != 5 || fd_a != 1) $display("FAIL mid_summary: writes %0d frame_done %0d, expected 5 1", popped_a.size(), fd_a);
      else n_pass++;
   endtask

   task automatic test_ignored_excess();
      do_reset();
      rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         pv = (i < 28); sof = (i == 8);
         pix = (i < 8) ? 8'(8'hA0 + i) : 8'(i - 8);
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vec(d) !== exp_vec(d)) $display("FAIL ign_model dut%0d cyc %0d: got %h, expected %h", d, cyc, act_vec(d), exp_vec(d));
            else n_pass++;
         end
         if (i == 7) begin
            n_checks++;
            if (popped_a.size() != 0 || if_a.busy !== 1'b0 || if_a.wr_en_l !== 1'b1)
               $display("FAIL ign_no_sof: writes %0d busy %b wr_en_l %b, expected 0 0 1", popped_a.size(), if_a.busy, if_a.wr_en_l);
            else n_pass++;
         end
      end
      n_checks++;
      if (popped_a.size() != 4 || fd_a != 1) $display("FAIL ign_excess: writes %0d frame_done %0d, expected 4 1", popped_a.size(), fd_a);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int budget;
      do_reset();
      rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pv = 1'b1; sof = (i == 0); pix = 8'(i);
         tick();
      end
      pv = 1'b0; sof = 1'b0; budget = 0;
      while (if_a.frame_done !== 1'b1 && budget < 20) begin
         tick();
         budget++;
      end
      n_checks++;
      if (if_a.frame_done !== 1'b1) $display("FAIL b2b_wait: frame_done %b after %0d cycles, expected 1", if_a.frame_done, budget);
      else n_pass++;
      for (int i = 0; i < 26; i++) begin
         pv = (i < 16); sof = (i == 0); pix = 8'(8'h40 + i);
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vec(d) !== exp_vec(d)) $display("FAIL b2b_model dut%0d cyc %0d: got %h, expected %h", d, cyc, act_vec(d), exp_vec(d));
            else n_pass++;
         end
      end
      n_checks++;
      if (popped_a.size() != 8 || popped_a[4] !== 32'h43424140 || popped_a[7] !== 32'h4F4E4D4C || fd_a != 2)
         $display("FAIL b2b_summary: writes %0d frame_done %0d, expected 8 2 with second frame 43424140..4F4E4D4C", popped_a.size(), fd_a);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         pv = 1'b1; sof = (i == 0); pix = 8'(i);
         tick();
      end
      n_checks++;
      if ({if_a.wr_en_l, if_a.busy, if_a.data_out} !== {2'b01, 32'h03020100})
         $display("FAIL rstmid_queued: wr_en_l/busy/data %b/%b/%h, expected 0/1/03020100", if_a.wr_en_l, if_a.busy, if_a.data_out);
      else n_pass++;
      pv = 1'b0; sof = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (act_vec(d) !== RST_VEC) $display("FAIL rstmid_values dut%0d: got %h, expected %h", d, act_vec(d), RST_VEC);
         else n_pass++;
      end
      rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vec(d) !== exp_vec(d)) $display("FAIL rstmid_model dut%0d cyc %0d: got %h, expected %h", d, cyc, act_vec(d), exp_vec(d));
            else n_pass++;
         end
      end
      n_checks++;
      if (fd_a != 0 || popped_a.size() != 0) $display("FAIL rstmid_quiet: frame_done %0d writes %0d, expected 0 0", fd_a, popped_a.size());
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         reset = ($urandom_range(0, 499) == 0);
         pv    = ($urandom_range(0, 9) < 8);
         sof   = pv && ($urandom_range(0, 47) == 0);
         pix   = 8'($urandom);
         rdy   = ($urandom_range(0, 9) < 7);
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vec(d) !== exp_vec(d)) $display("FAIL rand_model dut%0d cyc %0d: got %h, expected %h", d, cyc, act_vec(d), exp_vec(d));
            else n_pass++;
         end
      end
      reset = 1'b0;
      n_checks++;
      if (fd_a != m_frames[0] || fd_b != m_frames[1])
         $display("FAIL rand_frames: got %0d/%0d frame_done pulses, expected %0d/%0d", fd_a, fd_b, m_frames[0], m_frames[1]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_midframe_sof();
      test_ignored_excess();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1);
   end
endmodule
